// File: rtl/bram_port_arbiter.sv
// Arbitrates NumReq requesters onto one single-port BRAM with a 1-cycle registered read.
// Round-robin arbitration with an optional per-transfer lock that keeps the grant on the
// current owner. A read response comes back one cycle after the accepted read. An address
// at or beyond Depth is never written. A read at such an address returns an error response.
module bram_port_arbiter #(
    parameter int unsigned  DataWidth = 8,
    parameter int unsigned  Depth     = 1024,
    parameter int unsigned  NumReq    = 2,
    localparam int unsigned AW        = $clog2(Depth + 1),
    localparam int unsigned PtrW      = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq-1:0]           req_we_i,
    input  logic [NumReq-1:0]           req_lock_i,
    input  logic [NumReq*AW-1:0]        req_addr_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic [NumReq-1:0]           resp_valid_o,
    output logic                        resp_err_o,
    output logic [DataWidth-1:0]        resp_data_o,
    output logic                        mem_write_en_o,
    output logic [AW-1:0]               mem_addr_o,
    output logic [DataWidth-1:0]        mem_data_o,
    input  logic [DataWidth-1:0]        mem_data_i
);

    // Arbitration state
    logic [PtrW-1:0]   r_ptr;
    logic              r_lock_vld;
    logic [PtrW-1:0]   r_lock_own;
    // Pending read response
    logic [NumReq-1:0] r_resp_vld;
    logic              r_resp_err;

    logic [NumReq-1:0]    w_grant;
    logic [PtrW-1:0]      w_gidx;
    logic                 w_xfer;
    logic [PtrW:0]        w_sum;
    logic [PtrW-1:0]      w_idx;
    logic [AW-1:0]        w_addr;
    logic [DataWidth-1:0] w_wdata;
    logic                 w_we;
    logic                 w_lock;
    logic                 w_oob;

    logic [PtrW-1:0]      w_ptr_nxt;
    logic                 w_lock_vld_nxt;
    logic [PtrW-1:0]      w_lock_own_nxt;
    logic [NumReq-1:0]    w_resp_vld_nxt;
    logic                 w_resp_err_nxt;

    // Grant select: a valid lock owner wins, otherwise first valid index from the pointer
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_xfer  = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        if (r_lock_vld && req_valid_i[r_lock_own]) begin
            w_gidx = r_lock_own;
            w_xfer = 1'b1;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                w_sum = {1'b0, r_ptr} + (PtrW+1)'(i);
                if (w_sum >= (PtrW+1)'(NumReq)) begin
                    w_sum = w_sum - (PtrW+1)'(NumReq);
                end
                w_idx = w_sum[PtrW-1:0];
                if (!w_xfer && req_valid_i[w_idx]) begin
                    w_gidx = w_idx;
                    w_xfer = 1'b1;
                end
            end
        end
        if (w_xfer) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Mux the granted requester's command; everything stays zero when idle
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (w_grant[k]) begin
                w_addr  = req_addr_i[k*AW +: AW];
                w_wdata = req_data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    assign w_we   = |(w_grant & req_we_i);
    assign w_lock = |(w_grant & req_lock_i);
    assign w_oob  = (w_addr >= AW'(Depth));

    assign req_ready_o    = w_grant;
    assign mem_addr_o     = w_addr;
    assign mem_data_o     = w_wdata;
    // Gated by rst_ni so nothing is written while reset is held
    assign mem_write_en_o = rst_ni & w_xfer & w_we & ~w_oob;

    // Next pointer/lock: unlocked transfers advance past the winner; locked ones pin it
    always_comb begin
        w_ptr_nxt      = r_ptr;
        w_lock_vld_nxt = r_lock_vld;
        w_lock_own_nxt = r_lock_own;
        if (w_xfer) begin
            if (w_lock) begin
                w_lock_vld_nxt = 1'b1;
                w_lock_own_nxt = w_gidx;
            end else begin
                w_lock_vld_nxt = 1'b0;
                w_ptr_nxt      = (w_gidx == PtrW'(NumReq - 1)) ? '0 : w_gidx + 1'b1;
            end
        end else if (r_lock_vld && !req_valid_i[r_lock_own]) begin
            w_lock_vld_nxt = 1'b0;
        end
    end

    // Reads schedule a response for the next cycle; writes never respond
    always_comb begin
        w_resp_vld_nxt = '0;
        w_resp_err_nxt = 1'b0;
        if (w_xfer && !w_we) begin
            w_resp_vld_nxt = w_grant;
            w_resp_err_nxt = w_oob;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
            r_resp_vld <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_lock_vld <= w_lock_vld_nxt;
            r_lock_own <= w_lock_own_nxt;
            r_resp_vld <= w_resp_vld_nxt;
            r_resp_err <= w_resp_err_nxt;
        end
    end

    assign resp_valid_o = r_resp_vld;
    assign resp_err_o   = r_resp_err;
    // BRAM data passes through only for a good response; error or idle reads as zero
    assign resp_data_o  = (|r_resp_vld && !r_resp_err) ? mem_data_i : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed and random bench for bram_port_arbiter, checked against a behavioural model.
module tb_bram_port_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int N     = 2;
    localparam int AW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    valid, we, lock;
    logic [AW-1:0]   addr [N];
    logic [DW-1:0]   wdata[N];
    logic [N*AW-1:0] addr_bus;
    logic [N*DW-1:0] data_bus;

    logic [N-1:0]  ready, resp_valid;
    logic          resp_err, mem_we;
    logic [DW-1:0] resp_data, mem_wdata, bram_q;
    logic [AW-1:0] mem_addr;

    always_comb begin
        addr_bus = '0;
        data_bus = '0;
        for (int k = 0; k < N; k++) begin
            addr_bus[k*AW +: AW] = addr[k];
            data_bus[k*DW +: DW] = wdata[k];
        end
    end

    bram_port_arbiter #(
        .DataWidth (DW),
        .Depth     (DEPTH),
        .NumReq    (N)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (valid),
        .req_ready_o    (ready),
        .req_we_i       (we),
        .req_lock_i     (lock),
        .req_addr_i     (addr_bus),
        .req_data_i     (data_bus),
        .resp_valid_o   (resp_valid),
        .resp_err_o     (resp_err),
        .resp_data_o    (resp_data),
        .mem_write_en_o (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_data_i     (bram_q)
    );

    // Behavioural single-port BRAM with registered read, cleared on reset
    logic [DW-1:0] bram [DEPTH];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= '0;
            bram_q <= '0;
        end else begin
            if (mem_we && int'(mem_addr) < DEPTH) bram[int'(mem_addr)] <= mem_wdata;
            bram_q <= (int'(mem_addr) < DEPTH) ? bram[int'(mem_addr)] : '0;
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_ptr;
    int            m_owner;
    logic [DW-1:0] shadow [DEPTH];
    logic [N-1:0]  e_rv;
    logic          e_err;
    logic [DW-1:0] e_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        e_rv    = '0;
        e_err   = 1'b0;
        e_rdata = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    task automatic set_req(input int k, input bit v, input bit w, input bit l,
                           input int a, input int d);
        valid[k] = v;
        we[k]    = w;
        lock[k]  = l;
        addr[k]  = AW'(a);
        wdata[k] = DW'(d);
    endtask

    task automatic idle();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // One cycle: predict, check just after the inputs settle, then advance the model
    task automatic step(input string tag);
        int            g;
        logic [N-1:0]  er;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        g = -1;
        if (m_owner >= 0 && valid[m_owner]) g = m_owner;
        else begin
            for (int i = 0; i < N; i++) begin
                int idx = (m_ptr + i) % N;
                if (g < 0 && valid[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ea = (g >= 0) ? addr[g] : '0;
        ed = (g >= 0) ? wdata[g] : '0;
        ew = (g >= 0) && we[g] && (int'(addr[g]) < DEPTH);
        #1;
        chk({tag, ".ready"},     32'(ready),      32'(er));
        chk({tag, ".mem_we"},    32'(mem_we),     32'(ew));
        chk({tag, ".mem_addr"},  32'(mem_addr),   32'(ea));
        chk({tag, ".mem_data"},  32'(mem_wdata),  32'(ed));
        chk({tag, ".resp_vld"},  32'(resp_valid), 32'(e_rv));
        chk({tag, ".resp_err"},  32'(resp_err),   32'(e_err));
        chk({tag, ".resp_data"}, 32'(resp_data),  32'(e_rdata));
        @(posedge clk);
        e_rv    = '0;
        e_err   = 1'b0;
        e_rdata = '0;
        if (g >= 0) begin
            if (!we[g]) begin
                e_rv[g] = 1'b1;
                if (int'(addr[g]) >= DEPTH) e_err = 1'b1;
                else e_rdata = shadow[int'(addr[g])];
            end
            if (ew) shadow[int'(addr[g])] = wdata[g];
            if (lock[g]) m_owner = g;
            else begin
                m_owner = -1;
                m_ptr   = (g + 1) % N;
            end
        end else if (m_owner >= 0 && !valid[m_owner]) begin
            m_owner = -1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        // Write presented during reset must not reach the BRAM
        set_req(0, 1'b1, 1'b1, 1'b0, 5, 'h5A);
        #2;
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.resp_vld", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single write then read-back
        set_req(0, 1'b1, 1'b1, 1'b0, 5, 'hA5);
        step("wr5");
        set_req(0, 1'b1, 1'b0, 1'b0, 5, 0);
        step("rd5");
        idle();
        #1;
        chk("single.resp_vld", 32'(resp_valid), 32'b01);
        chk("single.resp_data", 32'(resp_data), 32'hA5);
        step("rsp5");

        // Contention: preload, then both read every cycle
        set_req(0, 1'b1, 1'b1, 1'b0, 1, 'h11);
        set_req(1, 1'b1, 1'b1, 1'b0, 2, 'h22);
        repeat (2) step("preload");
        set_req(0, 1'b1, 1'b0, 1'b0, 1, 0);
        set_req(1, 1'b1, 1'b0, 1'b0, 2, 0);
        repeat (6) step("contend");

        // Lock: req1 holds the grant for three transfers while req0 waits
        set_req(0, 1'b1, 1'b0, 1'b0, 1, 0);
        set_req(1, 1'b1, 1'b0, 1'b1, 2, 0);
        repeat (3) step("lock");
        set_req(1, 1'b0, 1'b0, 1'b0, 2, 0);
        step("unlock");
        set_req(1, 1'b1, 1'b0, 1'b0, 2, 0);
        step("after_unlock");
        idle();
        step("idle");

        // Bounds
        set_req(0, 1'b1, 1'b0, 1'b0, 1024, 0);
        step("oob_rd");
        set_req(0, 1'b1, 1'b1, 1'b0, 1024, 'hFF);
        step("oob_wr");
        set_req(0, 1'b1, 1'b1, 1'b0, 1023, 'h3C);
        step("last_wr");
        set_req(0, 1'b1, 1'b0, 1'b0, 1023, 0);
        step("last_rd");
        set_req(0, 1'b1, 1'b0, 1'b0, 2047, 0);
        step("max_rd");
        idle();
        step("idle2");

        // Reset while a read response is pending
        set_req(0, 1'b1, 1'b0, 1'b0, 1, 0);
        step("pre_rst_rd");
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.resp_vld", 32'(resp_valid), 32'd0);
        chk("midrst.resp_err", 32'(resp_err), 32'd0);
        chk("midrst.mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 3, 0);
        set_req(1, 1'b1, 1'b0, 1'b0, 4, 0);
        step("post_rst");
        step("post_rst2");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < N; k++) begin
                int r;
                int a;
                r = int'($urandom_range(0, 15));
                if (r == 0) a = 1024 + int'($urandom_range(0, 1023));
                else if (r == 1) a = 1023;
                else a = int'($urandom_range(0, 7));
                set_req(k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                        $urandom_range(0, 3) == 0, a, int'($urandom_range(0, 255)));
            end
            step("rnd");
        end
        idle();
        step("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
